// File: rtl/register_file_pkg.sv
// Shared constants for the register file slice.
//   DATA_WIDTH : width of each register and of the data buses
//   NUM_REGS   : number of architectural registers
//   ADDR_WIDTH : width of a register index
//   ZERO_REG   : index of the hardwired-zero register (XZR)
package register_file_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned ZERO_REG   = 31;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file: a NUM_REGS:1 mux over
// the register array. Whatever the array holds at ZERO_REG, reading that
// index always returns zero.
// Ports:
//   regs_i : full register array (packed, index 0 in the low slot)
//   addr_i : register index to read
//   data_o : selected register value, or zero for ZERO_REG
module regfile_read_port #(
  parameter int unsigned DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int unsigned NUM_REGS   = register_file_pkg::NUM_REGS,
  parameter int unsigned ZERO_REG   = register_file_pkg::ZERO_REG,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_i,
  input  logic [ADDR_WIDTH-1:0]               addr_i,
  output logic [DATA_WIDTH-1:0]               data_o
);

  always_comb begin
    data_o = regs_i[addr_i];
    if (addr_i == ADDR_WIDTH'(ZERO_REG)) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// Register file with one write port and two combinational read ports.
// State changes on the falling edge of Clk. Rst is synchronous and
// active-high and overrides a write on the same edge. Writes to ZERO_REG
// are dropped, and both read ports force that index to read zero.
// Ports:
//   Clk   : clock (falling edge active)
//   Rst   : synchronous active-high clear of all registers
//   BusW  : write data
//   RW    : write register index
//   RegWr : write enable
//   RA/RB : read port A/B index
//   BusA/BusB : read port A/B data (combinational)
module register_file #(
  parameter int unsigned DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int unsigned NUM_REGS   = register_file_pkg::NUM_REGS,
  parameter int unsigned ZERO_REG   = register_file_pkg::ZERO_REG,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] BusW,
  input  logic [ADDR_WIDTH-1:0] RW,
  input  logic                  RegWr,
  input  logic [ADDR_WIDTH-1:0] RA,
  input  logic [ADDR_WIDTH-1:0] RB,
  output logic [DATA_WIDTH-1:0] BusA,
  output logic [DATA_WIDTH-1:0] BusB
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

  // Write decode: only the addressed slot takes BusW; ZERO_REG never does.
  always_comb begin
    regs_d = regs_q;
    if (RegWr && (RW != ADDR_WIDTH'(ZERO_REG))) begin
      regs_d[RW] = BusW;
    end
  end

  always_ff @(negedge Clk) begin
    if (Rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ZERO_REG   (ZERO_REG)
  ) u_port_a (
    .regs_i (regs_q),
    .addr_i (RA),
    .data_o (BusA)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ZERO_REG   (ZERO_REG)
  ) u_port_b (
    .regs_i (regs_q),
    .addr_i (RB),
    .data_o (BusB)
  );

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        Clk;
  logic        Rst;
  logic [63:0] BusW;
  logic [4:0]  RW;
  logic        RegWr;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [63:0] BusA;
  logic [63:0] BusB;

  register_file #(
    .DATA_WIDTH (64),
    .NUM_REGS   (32),
    .ZERO_REG   (31)
  ) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .BusW  (BusW),
    .RW    (RW),
    .RegWr (RegWr),
    .RA    (RA),
    .RB    (RB),
    .BusA  (BusA),
    .BusB  (BusB)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [63:0] model [32];
  int          tests_run    = 0;
  int          tests_failed = 0;

  function automatic logic [63:0] rd(input logic [4:0] idx);
    return (idx == 5'd31) ? 64'h0 : model[idx];
  endfunction

  task automatic test_reset();
    Rst = 1'b1; RegWr = 1'b0; RW = '0; BusW = '0; RA = '0; RB = '0;
    @(negedge Clk); #1;
    Rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(31 - i);
      sb.push_back('{name:"reset_clear", a:64'h0, b:64'h0});
      #1;
      e = sb.pop_front(); tests_run++;
      if (BusA !== e.a || BusB !== e.b) begin
        tests_failed++;
        $display("FAIL %s idx=%0d: BusA=%h BusB=%h expected %h %h", e.name, i, BusA, BusB, e.a, e.b);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      RegWr = 1'b1; RW = 5'(i); BusW = 64'(i);
      @(negedge Clk); #1;
      if (i != 31) model[i] = 64'(i);
    end
    RegWr = 1'b0;
    RA = 5'd0; RB = 5'd1;
    sb.push_back('{name:"fill_0_1", a:64'd0, b:64'd1});
    #1;
    e = sb.pop_front(); tests_run++;
    if (BusA !== e.a || BusB !== e.b) begin
      tests_failed++;
      $display("FAIL %s: BusA=%h BusB=%h expected %h %h", e.name, BusA, BusB, e.a, e.b);
    end
    RA = 5'd31; RB = 5'd31;
    sb.push_back('{name:"fill_31_31", a:64'd0, b:64'd0});
    #1;
    e = sb.pop_front(); tests_run++;
    if (BusA !== e.a || BusB !== e.b) begin
      tests_failed++;
      $display("FAIL %s: BusA=%h BusB=%h expected %h %h", e.name, BusA, BusB, e.a, e.b);
    end
    for (int i = 0; i < 31; i++) begin
      RA = 5'(i); RB = 5'(30 - i);
      sb.push_back('{name:"fill_all", a:rd(RA), b:rd(RB)});
      #1;
      e = sb.pop_front(); tests_run++;
      if (BusA !== e.a || BusB !== e.b) begin
        tests_failed++;
        $display("FAIL %s idx=%0d: BusA=%h BusB=%h expected %h %h", e.name, i, BusA, BusB, e.a, e.b);
      end
    end
  endtask

  task automatic test_write_disabled();
    RegWr = 1'b0; RW = 5'd1; BusW = 64'h1000; RA = 5'd2; RB = 5'd3;
    @(negedge Clk); #1;
    sb.push_back('{name:"wdis_2_3", a:64'd2, b:64'd3});
    #1;
    e = sb.pop_front(); tests_run++;
    if (BusA !== e.a || BusB !== e.b) begin
      tests_failed++;
      $display("FAIL %s: BusA=%h BusB=%h expected %h %h", e.name, BusA, BusB, e.a, e.b);
    end
    RA = 5'd1; RB = 5'd1;
    sb.push_back('{name:"wdis_reg1", a:64'd1, b:64'd1});
    #1;
    e = sb.pop_front(); tests_run++;
    if (BusA !== e.a || BusB !== e.b) begin
      tests_failed++;
      $display("FAIL %s: BusA=%h BusB=%h expected %h %h", e.name, BusA, BusB, e.a, e.b);
    end
  endtask

  task automatic test_write_others();
    logic [4:0]  rws [2];
    logic [63:0] ws  [2];
    rws[0] = 5'd10; ws[0] = 64'h1010;
    rws[1] = 5'd11; ws[1] = 64'h103000;
    RA = 5'd6; RB = 5'd7;
    for (int k = 0; k < 2; k++) begin
      RegWr = 1'b1; RW = rws[k]; BusW = ws[k];
      @(negedge Clk); #1;
      model[rws[k]] = ws[k];
      sb.push_back('{name:"wother_6_7", a:64'd6, b:64'd7});
      #1;
      e = sb.pop_front(); tests_run++;
      if (BusA !== e.a || BusB !== e.b) begin
        tests_failed++;
        $display("FAIL %s k=%0d: BusA=%h BusB=%h expected %h %h", e.name, k, BusA, BusB, e.a, e.b);
      end
    end
    RegWr = 1'b0; RA = 5'd10; RB = 5'd11;
    sb.push_back('{name:"wother_10_11", a:64'h1010, b:64'h103000});
    #1;
    e = sb.pop_front(); tests_run++;
    if (BusA !== e.a || BusB !== e.b) begin
      tests_failed++;
      $display("FAIL %s: BusA=%h BusB=%h expected %h %h", e.name, BusA, BusB, e.a, e.b);
    end
  endtask

  task automatic test_write_then_read();
    RA = 5'd12; RB = 5'd13; RW = 5'd13; BusW = 64'hABCD; RegWr = 1'b1;
    sb.push_back('{name:"wtr_before", a:64'hC, b:64'hD});
    #1;
    e = sb.pop_front(); tests_run++;
    if (BusA !== e.a || BusB !== e.b) begin
      tests_failed++;
      $display("FAIL %s: BusA=%h BusB=%h expected %h %h", e.name, BusA, BusB, e.a, e.b);
    end
    @(negedge Clk); #1;
    model[13] = 64'hABCD;
    RegWr = 1'b0;
    sb.push_back('{name:"wtr_after", a:64'hC, b:64'hABCD});
    #1;
    e = sb.pop_front(); tests_run++;
    if (BusA !== e.a || BusB !== e.b) begin
      tests_failed++;
      $display("FAIL %s: BusA=%h BusB=%h expected %h %h", e.name, BusA, BusB, e.a, e.b);
    end
  endtask

  task automatic test_zero_reg();
    RW = 5'd31; BusW = 64'h12345678; RegWr = 1'b1;
    @(negedge Clk); #1;
    RegWr = 1'b0; RA = 5'd31; RB = 5'd31;
    sb.push_back('{name:"zero_31", a:64'h0, b:64'h0});
    #1;
    e = sb.pop_front(); tests_run++;
    if (BusA !== e.a || BusB !== e.b) begin
      tests_failed++;
      $display("FAIL %s: BusA=%h BusB=%h expected %h %h", e.name, BusA, BusB, e.a, e.b);
    end
    RA = 5'd30; RB = 5'd0;
    sb.push_back('{name:"zero_neighbours", a:64'd30, b:64'd0});
    #1;
    e = sb.pop_front(); tests_run++;
    if (BusA !== e.a || BusB !== e.b) begin
      tests_failed++;
      $display("FAIL %s: BusA=%h BusB=%h expected %h %h", e.name, BusA, BusB, e.a, e.b);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 40; c++) begin
      RegWr = 1'($urandom_range(0, 1));
      RW    = 5'($urandom_range(0, 31));
      BusW  = {$urandom, $urandom};
      RA    = 5'($urandom_range(0, 31));
      RB    = (c % 4 == 0) ? RA : 5'($urandom_range(0, 31));
      sb.push_back('{name:"b2b_pre_edge", a:rd(RA), b:rd(RB)});
      #1;
      e = sb.pop_front(); tests_run++;
      if (BusA !== e.a || BusB !== e.b) begin
        tests_failed++;
        $display("FAIL %s c=%0d RA=%0d RB=%0d: BusA=%h BusB=%h expected %h %h",
                 e.name, c, RA, RB, BusA, BusB, e.a, e.b);
      end
      @(negedge Clk); #1;
      if (RegWr && RW != 5'd31) model[RW] = BusW;
    end
    RegWr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(i);
      sb.push_back('{name:"b2b_sweep", a:rd(RA), b:rd(RB)});
      #1;
      e = sb.pop_front(); tests_run++;
      if (BusA !== e.a || BusB !== e.b) begin
        tests_failed++;
        $display("FAIL %s idx=%0d: BusA=%h BusB=%h expected %h %h", e.name, i, BusA, BusB, e.a, e.b);
      end
    end
  endtask

  task automatic test_reset_priority();
    Rst = 1'b1; RegWr = 1'b1; RW = 5'd5; BusW = 64'hFFFF;
    @(negedge Clk); #1;
    Rst = 1'b0; RegWr = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(i ^ 1);
      sb.push_back('{name:"rst_prio_clear", a:64'h0, b:64'h0});
      #1;
      e = sb.pop_front(); tests_run++;
      if (BusA !== e.a || BusB !== e.b) begin
        tests_failed++;
        $display("FAIL %s idx=%0d: BusA=%h BusB=%h expected %h %h", e.name, i, BusA, BusB, e.a, e.b);
      end
    end
    RegWr = 1'b1; RW = 5'd5; BusW = 64'hFFFF;
    @(negedge Clk); #1;
    model[5] = 64'hFFFF;
    RegWr = 1'b0; RA = 5'd5; RB = 5'd4;
    sb.push_back('{name:"rst_then_write", a:64'hFFFF, b:64'h0});
    #1;
    e = sb.pop_front(); tests_run++;
    if (BusA !== e.a || BusB !== e.b) begin
      tests_failed++;
      $display("FAIL %s: BusA=%h BusB=%h expected %h %h", e.name, BusA, BusB, e.a, e.b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_write_disabled();
    test_write_others();
    test_write_then_read();
    test_zero_reg();
    test_back_to_back();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high, named Clk and Rst.
REQ-002 Parameter DATA_WIDTH, default 64, SHALL set the register and bus width in bits.
REQ-003 Parameter NUM_REGS, default 32, SHALL set the register count; the address width is log2(NUM_REGS), which is 5.
REQ-004 Parameter ZERO_REG, default 31, SHALL set the index of the hardwired-zero register (XZR).
REQ-005 Clk: input, 1 bit; all state changes SHALL occur on its falling edge.
REQ-006 Rst: input, 1 bit; synchronous, active-high clear of all registers.
REQ-007 BusW: input, 64 bits; write data.
REQ-008 RW: input, 5 bits; write register index.
REQ-009 RegWr: input, 1 bit; write enable.
REQ-010 RA: input, 5 bits; read port A index.
REQ-011 RB: input, 5 bits; read port B index.
REQ-012 BusA: output, 64 bits; data of register RA.
REQ-013 BusB: output, 64 bits; data of register RB.

Function
REQ-014 Storage SHALL be 32 registers of 64 bits each; indices 0 to 30 are general-purpose and writable, including register 0.
REQ-015 BusA SHALL equal reg[RA] and BusB SHALL equal reg[RB]; both reads are combinational, with no clock, and outputs follow address changes in the same cycle, settling well under 4 ns.
REQ-016 Reading index 31 SHALL return 64'h0 on either port, always.
REQ-017 On a Clk falling edge with RegWr=1, Rst=0 and RW not equal to 31, reg[RW] SHALL load BusW.
REQ-018 A write with RW=31 SHALL be discarded; register 31 reads 0 afterwards.
REQ-019 With RegWr=0, no register SHALL change, whatever the values of RW and BusW.
REQ-020 Write-then-read: after the falling edge that writes reg[n], a port addressing n SHALL show the new value. Before that edge, the port SHALL show the old value; there is no write-through bypass before the edge.
REQ-021 RA and RB may be equal; both ports SHALL then show the same value.
REQ-022 A write SHALL affect only reg[RW]; every other register is unchanged.

Reset
REQ-023 On a Clk falling edge with Rst=1, all 32 registers SHALL be cleared to 0, so BusA and BusB read 0 for every index.
REQ-024 Rst SHALL take priority over a write on the same edge.
REQ-025 Register contents before the first reset are undefined, except that index 31 always reads 0.
REQ-026 Read ports SHALL remain combinational during reset.

Structure
REQ-027 A shared package SHALL hold DATA_WIDTH, NUM_REGS, ADDR_WIDTH=5 and ZERO_REG=31.
REQ-028 One sub-module SHALL exist: regfile_read_port, a 32:1 x 64-bit read mux with index-31 zero forcing, instantiated twice for ports A and B.
REQ-029 The write decode and register array SHALL live in register_file; there are no latches and no tri-states.

Verification
REQ-030 Fill: write reg[i]=i for i=0..30, and attempt reg 31 with value 31. Then RA=0, RB=1 with RegWr=0 -> BusA=0, BusB=1; RA=RB=31 -> both 0.
REQ-031 Write disabled: RegWr=0, RW=1, BusW=64'h1000, RA=2, RB=3, then one clock -> BusA=2, BusB=3, and reg1 still reads 1.
REQ-032 Write to one register, read others: RegWr=1, RW=10, BusW=64'h1010 and RW=11, BusW=64'h103000 on two edges. Reading RA=6, RB=7 during these -> 6 and 7 unchanged. Afterwards RA=10, RB=11 -> 64'h1010 and 64'h103000.
REQ-033 Write then read same register: RA=12, RB=13, RW=13, BusW=64'hABCD, RegWr=1. Before the falling edge -> BusA=12 (64'hC), BusB=13 (64'hD). After the falling edge -> BusA=12 (64'hC), BusB=64'hABCD.
REQ-034 Zero register: RW=31, BusW=64'h12345678, RegWr=1, then one clock -> RA=RB=31 read 0.
REQ-035 Reset: Rst=1 with RegWr=1, RW=5, BusW=64'hFFFF on one edge -> all indices, including 5, read 0. Then Rst=0 and a write to reg 5 -> reg 5 reads 64'hFFFF.
